// File: rtl/core_pkg.sv
// core_pkg: shared core types and constants (fetch FSM, NOP encoding, ROM window).
package core_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int unsigned ROM_BYTES = 4096;
endpackage

// File: rtl/pc_legal_check.sv
// pc_legal_check: combinational word-alignment and address-window check.
module pc_legal_check #(
  parameter int W = 32,
  parameter logic [W-1:0] BASE = '0,
  parameter int unsigned BYTES = 4
) (
  input  logic [W-1:0] addr_i,
  output logic         legal_o
);
  localparam logic [W-1:0] LAST = BASE + W'(BYTES) - W'(4);
  assign legal_o = (addr_i[1:0] == 2'b00) && (addr_i >= BASE) && (addr_i <= LAST);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC ownership, ROM addressing and IF/ID register with stall, flush, redirect and fault halt.
module fetch_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = core_pkg::RESET_VECTOR,
  parameter int unsigned ROM_BYTES = core_pkg::ROM_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [INSTR_WIDTH-1:0]   rom_dout,
  output logic [INSTR_WIDTH-1:0]   instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     fault,
  output logic [ADDRESS_WIDTH-1:0] fault_pc
);
  import core_pkg::*;
  localparam logic [INSTR_WIDTH-1:0] BUBBLE = INSTR_WIDTH'(NOP);
  fetch_state_t state_q;
  logic [ADDRESS_WIDTH-1:0] pc_f_q, pc_d_q, pc_plus4_d_q, fault_pc_q, pc_plus4_f, npc;
  logic [INSTR_WIDTH-1:0] instr_d_q;
  logic valid_d_q, fault_q, npc_legal, bad_npc, bubble, load;
  pc_legal_check #(.W(ADDRESS_WIDTH), .BASE(RESET_VECTOR), .BYTES(ROM_BYTES)) u_check (
    .addr_i  (npc),
    .legal_o (npc_legal)
  );
  // A redirect squashes the word currently at pc_f: it is wrong-path.
  always_comb begin
    pc_plus4_f = pc_f_q + ADDRESS_WIDTH'(4);
    npc = pc_src_e ? pc_target_e : stall_f ? pc_f_q : pc_plus4_f;
    bad_npc = (npc != pc_f_q) && !npc_legal;
    bubble = (state_q == BOOT) || (state_q == RUN && flush_d)
          || (!stall_d && (state_q == HALT || (state_q == RUN && pc_src_e)));
    load = (state_q == RUN) && !flush_d && !stall_d && !pc_src_e;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_f_q <= RESET_VECTOR;
      instr_d_q <= BUBBLE;
      pc_d_q <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q <= 1'b0;
      fault_q <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      if (state_q == BOOT) state_q <= RUN;
      if (state_q == RUN) begin
        if (bad_npc) begin
          state_q <= HALT;
          fault_q <= 1'b1;
          fault_pc_q <= npc;
        end else pc_f_q <= npc;
      end
      if (bubble) begin
        instr_d_q <= BUBBLE;
        pc_d_q <= '0;
        pc_plus4_d_q <= '0;
        valid_d_q <= 1'b0;
      end else if (load) begin
        instr_d_q <= rom_dout;
        pc_d_q <= pc_f_q;
        pc_plus4_d_q <= pc_plus4_f;
        valid_d_q <= 1'b1;
      end
    end
  end
  assign pc_f = pc_f_q;
  assign instr_d = instr_d_q;
  assign pc_d = pc_d_q;
  assign pc_plus4_d = pc_plus4_d_q;
  assign valid_d = valid_d_q;
  assign fault = fault_q;
  assign fault_pc = fault_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario tasks for fetch_stage with a combinational ROM stub.
module tb_fetch_stage;
  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] NOPW = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0;
  logic [31:0] pc_f, rom_dout, instr_d, pc_d, pc_plus4_d, fault_pc;
  logic valid_d, fault;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;
  // ROM word encodes its own low address bits so expected data is easy to derive.
  assign rom_dout = {16'hC0DE, pc_f[15:0]};

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .pc_f(pc_f), .rom_dout(rom_dout),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .fault(fault), .fault_pc(fault_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (pc_f !== RV) begin n_err++; $display("FAIL reset_pc_f: got %h want %h", pc_f, RV); end
    n_chk++; if (valid_d !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_d); end
    n_chk++; if (instr_d !== NOPW) begin n_err++; $display("FAIL reset_instr: got %h want %h", instr_d, NOPW); end
    n_chk++; if (pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin n_err++; $display("FAIL reset_pc_d: got %h/%h want 0/0", pc_d, pc_plus4_d); end
    n_chk++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin n_err++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    step();
    n_chk++; if (pc_f !== RV || valid_d !== 1'b0) begin n_err++; $display("FAIL boot: got pc_f=%h valid=%b want %h/0", pc_f, valid_d, RV); end
    step();
    n_chk++; if (pc_f !== RV + 32'h4) begin n_err++; $display("FAIL first_pc_f: got %h want %h", pc_f, RV + 32'h4); end
    n_chk++; if (valid_d !== 1'b1 || pc_d !== RV) begin n_err++; $display("FAIL first_valid: got valid=%b pc_d=%h want 1/%h", valid_d, pc_d, RV); end
    n_chk++; if (instr_d !== 32'hC0DE0000 || pc_plus4_d !== RV + 32'h4) begin n_err++; $display("FAIL first_instr: got %h/%h want C0DE0000/%h", instr_d, pc_plus4_d, RV + 32'h4); end
    repeat (3) step();
    n_chk++; if (pc_f !== 32'hBFC00010 || pc_d !== 32'hBFC0000C || instr_d !== 32'hC0DE000C) begin n_err++; $display("FAIL seq_fetch: got %h/%h/%h want BFC00010/BFC0000C/C0DE000C", pc_f, pc_d, instr_d); end
  endtask

  task automatic test_stall();
    stall_f = 1'b1;
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (pc_f !== 32'hBFC00010 || pc_d !== 32'hBFC0000C || instr_d !== 32'hC0DE000C || valid_d !== 1'b1) begin n_err++; $display("FAIL stall_hold%0d: got %h/%h/%h/%b want BFC00010/BFC0000C/C0DE000C/1", i, pc_f, pc_d, instr_d, valid_d); end
    end
    stall_f = 1'b0;
    stall_d = 1'b0;
    step();
    n_chk++; if (pc_f !== 32'hBFC00014 || pc_d !== 32'hBFC00010 || instr_d !== 32'hC0DE0010) begin n_err++; $display("FAIL stall_resume: got %h/%h/%h want BFC00014/BFC00010/C0DE0010", pc_f, pc_d, instr_d); end
  endtask

  task automatic test_redirect();
    pc_src_e = 1'b1;
    pc_target_e = 32'hBFC00100;
    step();
    n_chk++; if (pc_f !== 32'hBFC00100 || valid_d !== 1'b0 || instr_d !== NOPW) begin n_err++; $display("FAIL redirect_bubble: got %h/%b/%h want BFC00100/0/%h", pc_f, valid_d, instr_d, NOPW); end
    pc_src_e = 1'b0;
    step();
    n_chk++; if (pc_f !== 32'hBFC00104 || valid_d !== 1'b1 || pc_d !== 32'hBFC00100 || instr_d !== 32'hC0DE0100) begin n_err++; $display("FAIL redirect_target: got %h/%b/%h/%h want BFC00104/1/BFC00100/C0DE0100", pc_f, valid_d, pc_d, instr_d); end
  endtask

  task automatic test_flush();
    flush_d = 1'b1;
    stall_d = 1'b1;
    step();
    n_chk++; if (valid_d !== 1'b0 || instr_d !== NOPW || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin n_err++; $display("FAIL flush_bubble: got %b/%h/%h/%h want 0/%h/0/0", valid_d, instr_d, pc_d, pc_plus4_d, NOPW); end
    n_chk++; if (pc_f !== 32'hBFC00108) begin n_err++; $display("FAIL flush_pc_f: got %h want BFC00108", pc_f); end
    flush_d = 1'b0;
    stall_d = 1'b0;
  endtask

  task automatic test_fault_align();
    pc_src_e = 1'b1;
    pc_target_e = 32'hBFC00102;
    step();
    n_chk++; if (fault !== 1'b1 || fault_pc !== 32'hBFC00102) begin n_err++; $display("FAIL align_fault: got %b/%h want 1/BFC00102", fault, fault_pc); end
    n_chk++; if (pc_f !== 32'hBFC00108 || valid_d !== 1'b0) begin n_err++; $display("FAIL align_hold: got %h/%b want BFC00108/0", pc_f, valid_d); end
    pc_target_e = 32'hBFC00200;
    step();
    n_chk++; if (pc_f !== 32'hBFC00108 || valid_d !== 1'b0 || fault !== 1'b1 || fault_pc !== 32'hBFC00102) begin n_err++; $display("FAIL halt_ignore: got %h/%b/%b/%h want BFC00108/0/1/BFC00102", pc_f, valid_d, fault, fault_pc); end
    pc_src_e = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (pc_f !== RV || fault !== 1'b0 || fault_pc !== 32'h0 || valid_d !== 1'b0) begin n_err++; $display("FAIL halt_async_reset: got %h/%b/%h/%b want %h/0/0/0", pc_f, fault, fault_pc, valid_d, RV); end
    #1 rst_n = 1'b1;
    step();
    step();
    n_chk++; if (valid_d !== 1'b1 || pc_d !== RV || pc_f !== RV + 32'h4) begin n_err++; $display("FAIL restart: got %b/%h/%h want 1/%h/%h", valid_d, pc_d, pc_f, RV, RV + 32'h4); end
  endtask

  task automatic test_fault_window();
    pc_src_e = 1'b1;
    pc_target_e = 32'hBFC01000;
    step();
    n_chk++; if (fault !== 1'b1 || fault_pc !== 32'hBFC01000 || pc_f !== RV + 32'h4 || valid_d !== 1'b0) begin n_err++; $display("FAIL window_fault: got %b/%h/%h/%b want 1/BFC01000/%h/0", fault, fault_pc, pc_f, valid_d, RV + 32'h4); end
    pc_src_e = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_seq_wrap();
    pc_src_e = 1'b1;
    pc_target_e = 32'hBFC00FFC;
    step();
    n_chk++; if (pc_f !== 32'hBFC00FFC || fault !== 1'b0) begin n_err++; $display("FAIL last_word_legal: got %h/%b want BFC00FFC/0", pc_f, fault); end
    pc_src_e = 1'b0;
    step();
    n_chk++; if (fault !== 1'b1 || fault_pc !== 32'hBFC01000 || pc_f !== 32'hBFC00FFC) begin n_err++; $display("FAIL wrap_fault: got %b/%h/%h want 1/BFC01000/BFC00FFC", fault, fault_pc, pc_f); end
    n_chk++; if (valid_d !== 1'b1 || pc_d !== 32'hBFC00FFC || instr_d !== 32'hC0DE0FFC) begin n_err++; $display("FAIL wrap_last_load: got %b/%h/%h want 1/BFC00FFC/C0DE0FFC", valid_d, pc_d, instr_d); end
    step();
    n_chk++; if (valid_d !== 1'b0 || pc_f !== 32'hBFC00FFC) begin n_err++; $display("FAIL halt_bubble: got %b/%h want 0/BFC00FFC", valid_d, pc_f); end
  endtask

  task automatic test_reset_stall();
    #1 rst_n = 1'b0;
    stall_f = 1'b1;
    #1 rst_n = 1'b1;
    step();
    n_chk++; if (pc_f !== RV || valid_d !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL boot_stall: got %h/%b/%b want %h/0/0", pc_f, valid_d, fault, RV); end
    step();
    n_chk++; if (pc_f !== RV || valid_d !== 1'b1 || pc_d !== RV) begin n_err++; $display("FAIL run_after_boot_stall: got %h/%b/%h want %h/1/%h", pc_f, valid_d, pc_d, RV, RV); end
    stall_d = 1'b1;
    repeat (2) step();
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (valid_d !== 1'b0 || pc_d !== 32'h0 || instr_d !== NOPW || pc_f !== RV) begin n_err++; $display("FAIL stall_async_reset: got %b/%h/%h/%h want 0/0/%h/%h", valid_d, pc_d, instr_d, pc_f, NOPW, RV); end
    stall_f = 1'b0;
    stall_d = 1'b0;
    #1 rst_n = 1'b1;
    step();
    step();
    n_chk++; if (valid_d !== 1'b1 || pc_d !== RV || instr_d !== 32'hC0DE0000) begin n_err++; $display("FAIL restart_after_stall: got %b/%h/%h want 1/%h/C0DE0000", valid_d, pc_d, instr_d, RV); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect();
    test_flush();
    test_fault_align();
    test_fault_window();
    test_seq_wrap();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core. It owns the program counter, drives the byte address into the combinational instruction ROM (little-endian, 4 KiB window at 0xBFC00000), and captures the returned word into the IF/ID pipeline register. It handles:
- stall and flush requests from the hazard unit,
- branch and jump redirects from the execute stage,
- halting on a fetch outside the ROM window or from a misaligned address.

## Interface
- ADDRESS_WIDTH, 32, PC and ROM address width
- INSTR_WIDTH, 32, instruction word width
- RESET_VECTOR, 32'hBFC00000, first fetch address; base of ROM window
- ROM_BYTES, 4096, ROM window size in bytes
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register
- flush_d  in  1  load a bubble into IF/ID
- pc_src_e  in  1  redirect request from execute
- pc_target_e  in  ADDRESS_WIDTH  redirect target
- pc_f  out  ADDRESS_WIDTH  current fetch address; connects to ROM addr
- rom_dout  in  INSTR_WIDTH  ROM read data, combinational from pc_f
- instr_d  out  INSTR_WIDTH  IF/ID instruction
- pc_d  out  ADDRESS_WIDTH  IF/ID PC
- pc_plus4_d  out  ADDRESS_WIDTH  IF/ID PC+4
- valid_d  out  1  IF/ID holds a real instruction
- fault  out  1  sticky; fetch halted
- fault_pc  out  ADDRESS_WIDTH  address that caused the fault

## Operation
- FSM states: BOOT, RUN, HALT. Reset sends the FSM to BOOT.
- BOOT
  - Lasts exactly one cycle; pc_f = RESET_VECTOR and is not advanced.
  - IF/ID loads a bubble.
  - Goes to RUN unconditionally, including when stall_f is high.
- RUN, next-PC selection:
  - pc_src_e=1: next PC = pc_target_e. This has priority over stall_f.
  - Otherwise stall_f=1: next PC = pc_f.
  - Otherwise: next PC = pc_f + 4, modulo 2^ADDRESS_WIDTH.
- RUN, fault check:
  - Applies to every candidate next PC that differs from pc_f.
  - Legal only if aligned ([1:0]=0) and RESET_VECTOR ≤ npc ≤ RESET_VECTOR+ROM_BYTES−4.
  - Checked at full width; sequential wrap past the window end is a fault.
  - Illegal candidate: PC is not updated, fault_pc ← candidate, fault ← 1, state → HALT.
- RUN, IF/ID register:
  - Priority: flush_d, then stall_d, then load.
  - flush_d=1: bubble (valid_d=0, instr_d=32'h00000013, pc_d and pc_plus4_d = 0).
  - stall_d=1: hold.
  - Load: instr_d←rom_dout, pc_d←pc_f, pc_plus4_d←pc_f+4, valid_d←1.
  - Exception: on a redirect cycle (pc_src_e=1 without stall_d), IF/ID loads a bubble, because the word at pc_f is wrong-path.
- HALT
  - PC frozen; IF/ID loads a bubble every cycle unless stall_d=1.
  - stall/redirect inputs are ignored.
  - Exit only via reset.
- Reset values: pc_f=RESET_VECTOR, instr_d=32'h00000013, pc_d=0, pc_plus4_d=0, valid_d=0, fault=0, fault_pc=0.

## Timing
- ROM is combinational: the instruction at pc_f appears on instr_d one edge after pc_f is presented. Fetch-to-decode latency is 1 cycle.
- First valid_d=1 occurs at the second rising edge after rst_n deasserts (BOOT cycle, then first RUN capture), with pc_d=RESET_VECTOR.
- Redirect:
  - pc_f = pc_target_e one edge after pc_src_e is sampled.
  - The first target instruction reaches IF/ID one edge later.
  - Exactly one bubble is inserted.
- stall_f and stall_d asserted together: pc_f and all IF/ID outputs are bit-identical across the stall.
- Asynchronous rst_n assertion mid-operation immediately forces all reset values, whatever the state.
- fault rises on the same edge that enters HALT; pc_f keeps the last legal address.

## Structure
- Shared package `core_pkg`:
  - fetch FSM state enum {BOOT, RUN, HALT};
  - NOP encoding 32'h00000013;
  - RESET_VECTOR and ROM_BYTES constants shared with the ROM.
- One sub-module, `pc_legal_check`: a combinational window/alignment checker. It is reused later for data-memory bounds checks.
- The IF/ID register lives inline in fetch_stage.

## Test plan
- Reset release, no stalls → pc_f sequence BFC00000 (BOOT), BFC00000, BFC00004, …; first valid_d=1 with pc_d=BFC00000, instr_d=ROM word 0.
- pc_src_e=1, pc_target_e=BFC00100 in cycle n → pc_f=BFC00100 at n+1; valid_d=0 at n+1; valid_d=1 with pc_d=BFC00100 at n+2.
- stall_f=stall_d=1 for 3 cycles at pc_f=BFC00010 → pc_f, instr_d, pc_d unchanged; resume at BFC00014.
- flush_d=1 together with stall_d=1 → bubble loaded (valid_d=0, instr_d=00000013).
- Redirect to BFC00102 → fault=1, fault_pc=BFC00102, pc_f holds previous value, valid_d=0 thereafter; same result for redirect to BFC01000; sequential fetch from BFC00FFC → fault_pc=BFC01000.
- rst_n pulsed low while in HALT and while stalled → outputs go to reset values immediately; restart from BOOT.
